// File: rtl/riscv_pc_pkg.sv
// Shared constants, types and helpers for the barrel-threaded PC front end.
package riscv_pc_pkg;

    localparam int INSTR_BYTES   = 4;
    localparam int PC_ALIGN_BITS = 2;

    typedef logic [31:0] pc_t;

    // Hart-id width; a single hart still needs a 1-bit id port.
    function automatic int hart_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping at N-1 -> 0.
module rr_arbiter
    import riscv_pc_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [hart_w(N)-1:0] ptr,
    output logic [hart_w(N)-1:0] gnt_idx,
    output logic                 gnt_any
);

    localparam int W = hart_w(N);

    int cand;

    // Scan offsets from farthest to nearest so the nearest requester wins last.
    always_comb begin
        gnt_idx = '0;
        gnt_any = 1'b0;
        cand    = 0;
        for (int i = N - 1; i >= 0; i--) begin
            cand = (int'(ptr) + i) % N;
            if (req[cand]) begin
                gnt_idx = W'(cand);
                gnt_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/multi_hart_pc.sv
// Per-hart PC file with round-robin fetch offer, valid/ready lock and per-hart redirects.
// Optional feature: define PC_MISALIGN_CHECK_EN to trap misaligned redirects to TRAP_VECTOR.
module multi_hart_pc
    import riscv_pc_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter int              NUM_HARTS    = 4,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(4)
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic [NUM_HARTS-1:0]         stall_mask,
    input  logic                         fetch_ready,
    output logic                         fetch_valid,
    output logic [XLEN-1:0]              fetch_pc,
    output logic [hart_w(NUM_HARTS)-1:0] fetch_hart,
    input  logic                         redirect_valid,
    input  logic [hart_w(NUM_HARTS)-1:0] redirect_hart,
    input  logic [XLEN-1:0]              redirect_pc
`ifdef PC_MISALIGN_CHECK_EN
    ,
    output logic                         misalign_valid,
    output logic [hart_w(NUM_HARTS)-1:0] misalign_hart,
    output logic [XLEN-1:0]              misalign_pc
`endif
);

    localparam int              HART_W     = hart_w(NUM_HARTS);
    localparam logic [HART_W-1:0] LAST_HART = HART_W'(NUM_HARTS - 1);
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((1 << PC_ALIGN_BITS) - 1);

    logic [XLEN-1:0]   pc_q [NUM_HARTS];
    logic [XLEN-1:0]   pc_d [NUM_HARTS];
    logic [HART_W-1:0] rr_ptr_q, rr_ptr_d;
    logic              lock_q, lock_d;
    logic [HART_W-1:0] locked_hart_q, locked_hart_d;

    logic [HART_W-1:0] arb_idx;
    logic              arb_any;
    logic [HART_W-1:0] sel;
    logic              handshake;
    logic              redirect_hit;
    logic [XLEN-1:0]   write_pc;

    rr_arbiter #(.N(NUM_HARTS)) u_arb (
        .req     (~stall_mask),
        .ptr     (rr_ptr_q),
        .gnt_idx (arb_idx),
        .gnt_any (arb_any)
    );

    // A held offer ignores stall_mask until fetch accepts it.
    assign sel         = lock_q ? locked_hart_q : arb_idx;
    assign fetch_valid = lock_q | arb_any;
    assign fetch_hart  = sel;
    assign handshake   = fetch_valid & fetch_ready;
    assign redirect_hit = redirect_valid && (int'(redirect_hart) < NUM_HARTS);

    always_comb begin
        fetch_pc = '0;
        for (int h = 0; h < NUM_HARTS; h++) begin
            if (sel == HART_W'(h)) fetch_pc = pc_q[h];
        end
    end

`ifdef PC_MISALIGN_CHECK_EN
    logic              misaligned;
    logic              misalign_valid_q, misalign_valid_d;
    logic [HART_W-1:0] misalign_hart_q, misalign_hart_d;
    logic [XLEN-1:0]   misalign_pc_q, misalign_pc_d;

    assign misaligned = |(redirect_pc & ALIGN_MASK);
    assign write_pc   = misaligned ? TRAP_VECTOR : redirect_pc;

    always_comb begin
        misalign_valid_d = redirect_hit & misaligned;
        misalign_hart_d  = misalign_valid_d ? redirect_hart : misalign_hart_q;
        misalign_pc_d    = misalign_valid_d ? redirect_pc : misalign_pc_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            misalign_valid_q <= 1'b0;
            misalign_hart_q  <= '0;
            misalign_pc_q    <= '0;
        end else begin
            misalign_valid_q <= misalign_valid_d;
            misalign_hart_q  <= misalign_hart_d;
            misalign_pc_q    <= misalign_pc_d;
        end
    end

    assign misalign_valid = misalign_valid_q;
    assign misalign_hart  = misalign_hart_q;
    assign misalign_pc    = misalign_pc_q;
`else
    localparam logic [XLEN-1:0] unused_trap_vector = TRAP_VECTOR;

    assign write_pc = redirect_pc & ~ALIGN_MASK;
`endif

    // Redirect is applied after the increment so it wins for the same hart.
    always_comb begin
        pc_d          = pc_q;
        rr_ptr_d      = rr_ptr_q;
        lock_d        = lock_q;
        locked_hart_d = locked_hart_q;
        if (handshake) begin
            rr_ptr_d = (sel == LAST_HART) ? '0 : sel + 1'b1;
            lock_d   = 1'b0;
        end else if (fetch_valid) begin
            lock_d        = 1'b1;
            locked_hart_d = sel;
        end
        for (int h = 0; h < NUM_HARTS; h++) begin
            if (handshake && sel == HART_W'(h)) pc_d[h] = pc_q[h] + XLEN'(INSTR_BYTES);
            if (redirect_hit && redirect_hart == HART_W'(h)) pc_d[h] = write_pc;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int h = 0; h < NUM_HARTS; h++) pc_q[h] <= RESET_VECTOR;
            rr_ptr_q      <= '0;
            lock_q        <= 1'b0;
            locked_hart_q <= '0;
        end else begin
            for (int h = 0; h < NUM_HARTS; h++) pc_q[h] <= pc_d[h];
            rr_ptr_q      <= rr_ptr_d;
            lock_q        <= lock_d;
            locked_hart_q <= locked_hart_d;
        end
    end

endmodule

// File: tb/tb_multi_hart_pc.sv
// Self-checking bench for multi_hart_pc: a 4-hart and a 3-hart instance share stimulus
// and are compared every cycle against an array-based reference model.
module tb_multi_hart_pc;
    import riscv_pc_pkg::*;

    localparam pc_t RESET_VEC = 32'h0000_0000;
    localparam pc_t TRAP_VEC  = 32'h0000_0004;

    logic       clock = 1'b0;
    logic       resetN;
    logic [3:0] stallMask;
    logic       fetchReady;
    logic       redirectValid;
    logic [1:0] redirectHart;
    pc_t        redirectPc;

    logic       fv4, fv3;
    pc_t        fpc4, fpc3;
    logic [1:0] fh4, fh3;
`ifdef PC_MISALIGN_CHECK_EN
    logic       mv4, mv3;
    logic [1:0] mh4, mh3;
    pc_t        mp4, mp3;
`endif

    int testsRun = 0;
    int testsFailed = 0;

    int   nhM [2];
    pc_t  pcM [2][16];
    int   rrM [2];
    bit   lockM [2];
    int   lhM [2];
    bit         expMisValid;
    logic [1:0] expMisHart;
    pc_t        expMisPc;

    typedef struct {
        logic [3:0] stall;
        logic       ready;
        int         expHart;
        pc_t        expPc;
    } vec_t;
    vec_t table1 [5];

    always #5 clock = ~clock;

    multi_hart_pc #(.XLEN(32), .NUM_HARTS(4), .RESET_VECTOR(RESET_VEC), .TRAP_VECTOR(TRAP_VEC)) dut4 (
        .clock(clock), .reset_n(resetN), .stall_mask(stallMask), .fetch_ready(fetchReady),
        .fetch_valid(fv4), .fetch_pc(fpc4), .fetch_hart(fh4),
        .redirect_valid(redirectValid), .redirect_hart(redirectHart), .redirect_pc(redirectPc)
`ifdef PC_MISALIGN_CHECK_EN
        , .misalign_valid(mv4), .misalign_hart(mh4), .misalign_pc(mp4)
`endif
    );

    multi_hart_pc #(.XLEN(32), .NUM_HARTS(3), .RESET_VECTOR(RESET_VEC), .TRAP_VECTOR(TRAP_VEC)) dut3 (
        .clock(clock), .reset_n(resetN), .stall_mask(stallMask[2:0]), .fetch_ready(fetchReady),
        .fetch_valid(fv3), .fetch_pc(fpc3), .fetch_hart(fh3),
        .redirect_valid(redirectValid), .redirect_hart(redirectHart), .redirect_pc(redirectPc)
`ifdef PC_MISALIGN_CHECK_EN
        , .misalign_valid(mv3), .misalign_hart(mh3), .misalign_pc(mp3)
`endif
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Hart the model would offer, or -1 when nothing is offered.
    function automatic int expectedHart(input int m);
        int h;
        if (lockM[m]) return lhM[m];
        for (int i = 0; i < nhM[m]; i++) begin
            h = (rrM[m] + i) % nhM[m];
            if (!stallMask[h]) return h;
        end
        return -1;
    endfunction

    task automatic resetModel();
        for (int m = 0; m < 2; m++) begin
            rrM[m] = 0;
            lockM[m] = 1'b0;
            lhM[m] = 0;
            for (int h = 0; h < 16; h++) pcM[m][h] = RESET_VEC;
        end
        expMisValid = 1'b0;
        expMisHart = 2'd0;
        expMisPc = 32'd0;
    endtask

    task automatic stepModel();
        int s;
        bit mis;
        mis = (redirectPc[1:0] != 2'b00);
        for (int m = 0; m < 2; m++) begin
            s = expectedHart(m);
            if (s >= 0 && fetchReady) begin
                pcM[m][s] = pcM[m][s] + 32'd4;
                rrM[m] = (s + 1) % nhM[m];
                lockM[m] = 1'b0;
            end else if (s >= 0) begin
                lockM[m] = 1'b1;
                lhM[m] = s;
            end
            if (redirectValid && int'(redirectHart) < nhM[m]) begin
`ifdef PC_MISALIGN_CHECK_EN
                pcM[m][redirectHart] = mis ? TRAP_VEC : redirectPc;
`else
                pcM[m][redirectHart] = {redirectPc[31:2], 2'b00};
`endif
            end
        end
        expMisValid = redirectValid && mis;
        if (expMisValid) begin
            expMisHart = redirectHart;
            expMisPc = redirectPc;
        end
    endtask

    task automatic compareModel();
        int e;
        for (int m = 0; m < 2; m++) begin
            e = expectedHart(m);
            checkOutput($sformatf("dut%0d valid", nhM[m]), (m == 0) ? fv4 : fv3, e >= 0);
            if (e >= 0) begin
                checkOutput($sformatf("dut%0d hart", nhM[m]), (m == 0) ? fh4 : fh3, e);
                checkOutput($sformatf("dut%0d pc", nhM[m]), (m == 0) ? fpc4 : fpc3, pcM[m][e]);
            end
        end
`ifdef PC_MISALIGN_CHECK_EN
        checkOutput("misalign valid", mv4, expMisValid);
        checkOutput("misalign hart", mh4, expMisHart);
        checkOutput("misalign pc", mp4, expMisPc);
`endif
    endtask

    task automatic applyStimulus(input logic [3:0] stall, input logic ready, input logic rv,
                                 input logic [1:0] rh, input pc_t rpc);
        stallMask = stall;
        fetchReady = ready;
        redirectValid = rv;
        redirectHart = rh;
        redirectPc = rpc;
        #1;
        compareModel();
    endtask

    task automatic tick();
        @(posedge clock);
        stepModel();
        #1;
    endtask

    initial begin
        pc_t r;
        nhM[0] = 4;
        nhM[1] = 3;
        table1[0] = '{4'b0000, 1'b1, 0, 32'h0};
        table1[1] = '{4'b0000, 1'b1, 1, 32'h0};
        table1[2] = '{4'b0000, 1'b1, 2, 32'h0};
        table1[3] = '{4'b0000, 1'b1, 3, 32'h0};
        table1[4] = '{4'b0000, 1'b1, 0, 32'h4};

        resetN = 1'b0;
        stallMask = 4'b0;
        fetchReady = 1'b0;
        redirectValid = 1'b0;
        redirectHart = 2'd0;
        redirectPc = 32'd0;
        resetModel();
        @(posedge clock);
        #1;
        compareModel();
        checkOutput("reset hart", fh4, 0);
        checkOutput("reset pc", fpc4, RESET_VEC);
        resetN = 1'b1;

        $display("[TB] round-robin table");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(table1[i].stall, table1[i].ready, 1'b0, 2'd0, 32'd0);
            checkOutput($sformatf("tbl%0d hart", i), fh4, table1[i].expHart);
            checkOutput($sformatf("tbl%0d pc", i), fpc4, table1[i].expPc);
            tick();
        end

        $display("[TB] lock hold and stall skip");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b0000, 1'b0, 1'b0, 2'd0, 32'd0);
            checkOutput("held hart", fh4, 1);
            tick();
        end
        applyStimulus(4'b0010, 1'b0, 1'b0, 2'd0, 32'd0);
        checkOutput("locked ignores stall", fh4, 1);
        tick();
        applyStimulus(4'b0010, 1'b1, 1'b0, 2'd0, 32'd0);
        checkOutput("locked accept", fh4, 1);
        tick();
        applyStimulus(4'b0010, 1'b1, 1'b0, 2'd0, 32'd0);
        checkOutput("after lock", fh4, 2);
        tick();
        for (int i = 0; i < 2; i++) begin
            applyStimulus(4'b0010, 1'b1, 1'b0, 2'd0, 32'd0);
            tick();
        end
        applyStimulus(4'b0010, 1'b1, 1'b0, 2'd0, 32'd0);
        checkOutput("hart1 skipped", fh4, 2);
        tick();

        $display("[TB] redirect beats increment");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b0000, 1'b1, 1'b0, 2'd0, 32'd0);
            tick();
        end
        applyStimulus(4'b0000, 1'b1, 1'b1, 2'd2, 32'h100);
        checkOutput("redir same hart", fh4, 2);
        tick();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b0000, 1'b1, 1'b0, 2'd0, 32'd0);
            tick();
        end
        applyStimulus(4'b0000, 1'b1, 1'b0, 2'd0, 32'd0);
        checkOutput("redir hart", fh4, 2);
        checkOutput("redir pc", fpc4, 32'h100);
        tick();

        $display("[TB] pc wrap");
        applyStimulus(4'b0000, 1'b1, 1'b1, 2'd0, 32'hFFFF_FFFC);
        tick();
        applyStimulus(4'b0000, 1'b1, 1'b0, 2'd0, 32'd0);
        checkOutput("wrap pre pc", fpc4, 32'hFFFF_FFFC);
        tick();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b0000, 1'b1, 1'b0, 2'd0, 32'd0);
            tick();
        end
        applyStimulus(4'b0000, 1'b1, 1'b0, 2'd0, 32'd0);
        checkOutput("wrap hart", fh4, 0);
        checkOutput("wrap pc", fpc4, 32'h0);
        tick();

        $display("[TB] three-hart stall patterns");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(4'b0101, 1'b1, 1'b0, 2'd0, 32'd0);
            checkOutput("dut3 only hart1", fh3, 1);
            tick();
        end
        applyStimulus(4'b0111, 1'b1, 1'b0, 2'd0, 32'd0);
        checkOutput("dut3 all stalled", fv3, 0);
        tick();
        applyStimulus(4'b1111, 1'b1, 1'b1, 2'd3, 32'h102);
        checkOutput("dut4 all stalled", fv4, 0);
        tick();

        $display("[TB] misaligned redirect");
        applyStimulus(4'b0111, 1'b1, 1'b0, 2'd0, 32'd0);
        checkOutput("misredir hart", fh4, 3);
`ifdef PC_MISALIGN_CHECK_EN
        checkOutput("misredir pc", fpc4, TRAP_VEC);
        checkOutput("misalign pulse", mv4, 1);
        checkOutput("misalign pc hand", mp4, 32'h102);
`else
        checkOutput("misredir pc", fpc4, 32'h100);
`endif
        tick();
`ifdef PC_MISALIGN_CHECK_EN
        applyStimulus(4'b0000, 1'b1, 1'b0, 2'd0, 32'd0);
        checkOutput("misalign one cycle", mv4, 0);
        tick();
`endif

        $display("[TB] reset while locked");
        applyStimulus(4'b0000, 1'b0, 1'b0, 2'd0, 32'd0);
        tick();
        applyStimulus(4'b0000, 1'b0, 1'b1, 2'd1, 32'h200);
        tick();
        #2;
        resetN = 1'b0;
        #1;
        resetModel();
        compareModel();
        checkOutput("async reset hart", fh4, 0);
        checkOutput("async reset pc", fpc4, RESET_VEC);
        @(posedge clock);
        #1;
        resetN = 1'b1;

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            r = $urandom;
            if ($urandom_range(0, 3) != 0) r[1:0] = 2'b00;
            if ($urandom_range(0, 7) == 0) r = 32'hFFFF_FFF8;
            applyStimulus(4'($urandom_range(0, 15) & $urandom_range(0, 15)),
                          ($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 3) == 0),
                          2'($urandom_range(0, 3)), r);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
